// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin Common Data Bus arbiter with branch-result priority
//            and a registered one-cycle broadcast. Optional per-unit grant
//            counters are enabled by defining CDB_ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 6,
  parameter int NUM_REQ        = 4,
  parameter int PERF_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_branch,
  input  logic [NUM_REQ-1:0]              req_branch_taken,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            CDB_valid,
  output logic [TAG_WIDTH-1:0]            CDB_tag,
  output logic [DATA_WIDTH-1:0]           CDB_data,
  output logic                            CDB_branch,
  output logic                            CDB_branch_taken
`ifdef CDB_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*PERF_CNT_WIDTH-1:0] perf_grant_cnt
`endif
);

  // A single requester still gets a 1-bit pointer that never leaves 0.
  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [c_PTR_W-1:0] f_wrap(input int v);
    return c_PTR_W'(v % NUM_REQ);
  endfunction

  logic [c_PTR_W-1:0]    r_rr_ptr;
  logic [c_PTR_W-1:0]    w_gnt_idx;
  logic [c_PTR_W-1:0]    w_rr_ptr_nxt;
  logic                  w_gnt_any;
  logic [NUM_REQ-1:0]    w_grant;

  logic                  r_cdb_valid;
  logic [TAG_WIDTH-1:0]  r_cdb_tag;
  logic [DATA_WIDTH-1:0] r_cdb_data;
  logic                  r_cdb_branch;
  logic                  r_cdb_branch_taken;

  // Branch resolutions win outright (lowest index); otherwise rotate from rr_ptr.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_gnt_any && req_valid[i] && req_branch[i]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = c_PTR_W'(i);
        end
      end
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!w_gnt_any && req_valid[f_wrap(int'(r_rr_ptr) + off)]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = f_wrap(int'(r_rr_ptr) + off);
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_gnt_any) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_rr_ptr_nxt = f_wrap(int'(w_gnt_idx) + 1);
  assign grant        = w_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr           <= '0;
      r_cdb_valid        <= 1'b0;
      r_cdb_tag          <= '0;
      r_cdb_data         <= '0;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end else begin
      r_cdb_valid <= w_gnt_any;
      // Payload fields hold when idle; consumers qualify with CDB_valid.
      if (w_gnt_any) begin
        r_rr_ptr           <= w_rr_ptr_nxt;
        r_cdb_tag          <= req_tag[w_gnt_idx*TAG_WIDTH +: TAG_WIDTH];
        r_cdb_data         <= req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        r_cdb_branch       <= req_branch[w_gnt_idx];
        r_cdb_branch_taken <= req_branch[w_gnt_idx] & req_branch_taken[w_gnt_idx];
      end
    end
  end

  assign CDB_valid        = r_cdb_valid;
  assign CDB_tag          = r_cdb_tag;
  assign CDB_data         = r_cdb_data;
  assign CDB_branch       = r_cdb_branch;
  assign CDB_branch_taken = r_cdb_branch_taken;

`ifdef CDB_ARB_PERF_CNT_EN
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_perf
      logic [PERF_CNT_WIDTH-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_grant[k] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign perf_grant_cnt[k*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
